// File: rtl/block_puncturer.sv
// block_puncturer: drops interleaver pad cells and reframes the surviving codeword
module block_puncturer #(
    parameter int NUMBER_OF_LINES   = 3,
    parameter int NUMBER_OF_COLUMNS = 4,
    parameter int PAD               = 2,
    parameter int WORD_LENGTH       = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_valid,
    input  logic                   i_start_cw,
    input  logic                   i_end_cw,
    input  logic [WORD_LENGTH-1:0] i_data,
    output logic                   o_consume,
    input  logic                   i_consume,
    output logic                   o_valid,
    output logic                   o_start_cw,
    output logic                   o_end_cw,
    output logic [WORD_LENGTH-1:0] o_data,
    output logic                   o_error
);
    localparam int D  = NUMBER_OF_LINES;
    localparam int M  = NUMBER_OF_COLUMNS;
    localparam int N  = D * M;
    localparam int CW = $clog2(N);
    localparam int RW = D > 1 ? $clog2(D) : 1;
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    logic [1:0]    state;
    logic [RW-1:0] row;
    logic [CW-1:0] col, out_cnt, k;
    logic          pad, last, hold, xfer, err;
    // index decode, handshake and framing-error detection
    always_comb begin
        k         = col * CW'(D) + CW'(row);
        pad       = row == RW'(D - 1) && col >= CW'(M - PAD);
        last      = k == CW'(N - 1);
        hold      = o_valid && !i_consume;
        o_consume = i_valid && state != DRAIN && (pad || !hold);
        xfer      = o_consume;
        err       = state == IDLE ? i_valid && (!i_start_cw || i_end_cw)
                  : state == RUN  ? xfer && (i_start_cw || i_end_cw != last)
                  : i_valid;
    end
    // counters, state and the one-deep output register
    always_ff @(posedge clk) begin
        if (rst || err) begin
            state      <= IDLE;
            row        <= '0;
            col        <= '0;
            out_cnt    <= '0;
            o_valid    <= 1'b0;
            o_start_cw <= 1'b0;
            o_end_cw   <= 1'b0;
            o_data     <= '0;
            o_error    <= err && !rst;
        end else begin
            o_error <= 1'b0;
            if (o_valid && i_consume) begin
                o_valid    <= 1'b0;
                o_start_cw <= 1'b0;
                o_end_cw   <= 1'b0;
            end
            if (xfer && !pad) begin
                o_valid    <= 1'b1;
                o_data     <= i_data;
                o_start_cw <= k == '0;
                o_end_cw   <= out_cnt == CW'(N - PAD - 1);
                out_cnt    <= out_cnt + 1'b1;
            end
            if (xfer) begin
                if (last) begin
                    row     <= '0;
                    col     <= '0;
                    out_cnt <= '0;
                    state   <= (!pad || hold) ? DRAIN : IDLE;
                end else begin
                    row   <= row == RW'(D - 1) ? '0 : row + 1'b1;
                    col   <= row == RW'(D - 1) ? col + 1'b1 : col;
                    state <= RUN;
                end
            end else if (state == DRAIN && i_consume) begin
                state <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_block_puncturer.sv
// tb_block_puncturer: randomized scoreboard bench plus directed framing and S=0 cases
module tb_block_puncturer;
    localparam int D = 3, M = 4, S = 2, WL = 3, N = D * M;
    logic clk = 0, rst = 1;
    always #5 clk = ~clk;
    logic i_valid = 0, i_start_cw = 0, i_end_cw = 0, i_consume = 0;
    logic [WL-1:0] i_data = '0;
    logic o_consume, o_valid, o_start_cw, o_end_cw, o_error;
    logic [WL-1:0] o_data;
    logic v2 = 0, s2 = 0, e2 = 0, c2 = 0;
    logic [WL-1:0] d2 = '0;
    logic oc2, ov2, os2, oe2, oerr2;
    logic [WL-1:0] od2;
    block_puncturer #(.NUMBER_OF_LINES(D), .NUMBER_OF_COLUMNS(M), .PAD(S), .WORD_LENGTH(WL)) dut (
        .clk(clk), .rst(rst), .i_valid(i_valid), .i_start_cw(i_start_cw), .i_end_cw(i_end_cw),
        .i_data(i_data), .o_consume(o_consume), .i_consume(i_consume), .o_valid(o_valid),
        .o_start_cw(o_start_cw), .o_end_cw(o_end_cw), .o_data(o_data), .o_error(o_error));
    block_puncturer #(.NUMBER_OF_LINES(2), .NUMBER_OF_COLUMNS(2), .PAD(0), .WORD_LENGTH(WL)) dut0 (
        .clk(clk), .rst(rst), .i_valid(v2), .i_start_cw(s2), .i_end_cw(e2),
        .i_data(d2), .o_consume(oc2), .i_consume(c2), .o_valid(ov2),
        .o_start_cw(os2), .o_end_cw(oe2), .o_data(od2), .o_error(oerr2));
    int checks = 0, errors = 0;
    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d required %0d", name, act, exp);
        end
    endtask
    typedef struct packed {logic [WL-1:0] d; logic s; logic e;} out_t;
    out_t sb[$];
    out_t log_q[$];
    bit model_on = 0;
    int mk = 0, mo = 0, cons_mode = 0;
    function automatic bit is_pad(input int k);
        return (k % D == D - 1) && (k / D >= M - S);
    endfunction
    // reference model: expected output stream as a queue of surviving symbols
    always @(negedge clk) begin
        if (model_on) begin
            chk("o_error", o_error, 0);
            chk("o_valid", o_valid, sb.size() > 0);
            if (o_valid && sb.size() > 0) begin
                chk("o_data", o_data, sb[0].d);
                chk("o_start_cw", o_start_cw, sb[0].s);
                chk("o_end_cw", o_end_cw, sb[0].e);
            end
            if (!rst) chk("o_consume", o_consume, i_valid && (is_pad(mk) || !o_valid || i_consume));
        end
        if (rst) begin
            sb.delete();
            mk = 0;
            mo = 0;
        end else begin
            if (o_valid && i_consume && sb.size() > 0) begin
                log_q.push_back(sb[0]);
                void'(sb.pop_front());
            end
            if (i_valid && o_consume) begin
                if (!is_pad(mk)) begin
                    sb.push_back('{d: i_data, s: mk == 0, e: mo == N - S - 1});
                    mo++;
                end
                mk = mk == N - 1 ? 0 : mk + 1;
                if (mk == 0) mo = 0;
            end
        end
    end
    // downstream consumer: always ready or randomly stalling
    always @(posedge clk) begin
        #1;
        if (cons_mode == 0) i_consume = 1;
        else if (cons_mode == 1) i_consume = $urandom_range(0, 3) != 0;
    end
    task automatic send(input logic [WL-1:0] d, input bit s, input bit e);
        int t = 0;
        i_valid = 1; i_data = d; i_start_cw = s; i_end_cw = e;
        @(negedge clk);
        while (!o_consume && t < 50) begin
            t++;
            @(negedge clk);
        end
        if (!o_consume) begin
            checks++; errors++;
            $display("FAIL consume_timeout o_consume stuck at 0");
        end
        @(posedge clk);
        #1;
        i_valid = 0; i_start_cw = 0; i_end_cw = 0;
    endtask
    task automatic wait_idle();
        int t = 0;
        @(negedge clk);
        while (o_valid && t < 100) begin
            t++;
            @(negedge clk);
        end
        if (o_valid) begin
            checks++; errors++;
            $display("FAIL drain_timeout o_valid stuck at 1");
        end
        @(posedge clk);
        #1;
    endtask
    task automatic codeword(input bit gaps);
        logic [WL-1:0] d;
        for (int k = 0; k < N; k++) begin
            d = WL'($urandom);
            send(d, k == 0, k == N - 1);
            if (gaps && $urandom_range(0, 3) == 0)
                repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
        end
        wait_idle();
    endtask
    task automatic reset_pulse();
        rst = 1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 0;
    endtask
    initial begin
        logic [WL-1:0] exp_d [10] = '{0, 1, 2, 3, 4, 5, 6, 7, 1, 2};
        logic [WL-1:0] d;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        model_on = 1;
        cons_mode = 0;
        // directed stream 0..11 with an always-ready consumer
        log_q.delete();
        for (int k = 0; k < N; k++) begin
            d = WL'(k);
            send(d, k == 0, k == N - 1);
        end
        wait_idle();
        chk("n_out", log_q.size(), 10);
        for (int i = 0; i < 10 && i < log_q.size(); i++) begin
            chk("lit_data", log_q[i].d, exp_d[i]);
            chk("lit_start", log_q[i].s, i == 0);
            chk("lit_end", log_q[i].e, i == 9);
        end
        // reset in the middle of a codeword
        for (int k = 0; k < 6; k++) begin
            d = WL'(k);
            send(d, k == 0, 0);
        end
        chk("pre_rst_valid", o_valid, 1);
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        chk("rst_valid", o_valid, 0);
        chk("rst_error", o_error, 0);
        @(posedge clk); #1;
        codeword(0);
        // randomized codewords with stalls and gaps
        cons_mode = 1;
        for (int n = 0; n < 30; n++) begin
            codeword(1);
            if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 4)) begin @(posedge clk); #1; end
        end
        // framing errors
        model_on = 0;
        cons_mode = 0;
        @(posedge clk); #1;
        i_valid = 1; i_data = 3;
        @(posedge clk); #1;
        i_valid = 0;
        @(negedge clk);
        chk("err_nostart", o_error, 1);
        @(negedge clk);
        chk("err_pulse_len", o_error, 0);
        @(posedge clk); #1;
        for (int k = 0; k < 6; k++) begin
            d = WL'(k);
            send(d, k == 0, 0);
        end
        i_valid = 1; i_start_cw = 1; i_data = 6;
        @(posedge clk); #1;
        i_valid = 0; i_start_cw = 0;
        @(negedge clk);
        chk("err_restart", o_error, 1);
        chk("err_restart_valid", o_valid, 0);
        @(negedge clk);
        chk("err_restart_clear", o_error, 0);
        @(posedge clk); #1;
        for (int k = 0; k < 9; k++) begin
            d = WL'(k);
            send(d, k == 0, 0);
        end
        i_valid = 1; i_end_cw = 1; i_data = 1;
        @(posedge clk); #1;
        i_valid = 0; i_end_cw = 0;
        @(negedge clk);
        chk("err_early_end", o_error, 1);
        chk("err_early_end_valid", o_valid, 0);
        @(posedge clk); #1;
        // recovery after errors
        reset_pulse();
        model_on = 1;
        cons_mode = 1;
        codeword(1);
        cons_mode = 0;
        // S=0, 2x2 pass-through with a drain phase
        c2 = 1;
        for (int k = 0; k < 4; k++) begin
            v2 = 1; d2 = WL'(k + 1); s2 = k == 0; e2 = k == 3;
            @(negedge clk);
            chk("p0_consume", oc2, 1);
            chk("p0_valid", ov2, k > 0);
            if (k > 0) begin
                chk("p0_data", od2, k);
                chk("p0_start", os2, k == 1);
                chk("p0_end", oe2, 0);
            end
            @(posedge clk); #1;
        end
        v2 = 0; s2 = 0; e2 = 0; c2 = 0;
        repeat (3) begin
            @(negedge clk);
            chk("p0_drain_valid", ov2, 1);
            chk("p0_drain_data", od2, 4);
            chk("p0_drain_end", oe2, 1);
            chk("p0_drain_err", oerr2, 0);
        end
        c2 = 1;
        @(posedge clk); #1;
        c2 = 0;
        @(negedge clk);
        chk("p0_done_valid", ov2, 0);
        chk("p0_done_err", oerr2, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
    initial begin
        #500000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1);
    end
endmodule
